// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the miniRV instruction-fetch sequencer.
//   state_t          - fetch FSM states (IDLE, REQ, WAIT, OUT)
//   NOP_INST         - instruction shown to decode before the first fetch
//   RESET_PC_DEFAULT - default PC loaded on reset
//   align_word()     - clears the two low address bits
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the architectural PC, issues one
// imem request at a time (req/gnt/rvalid), presents the fetched word to decode and
// squashes fetches made stale by a redirect from execute.
// Ports:
//   clk, rst                    - core clock, asynchronous active-high reset
//   imem_req/imem_addr          - fetch request (held until granted) and word address
//   imem_gnt/imem_rvalid/rdata  - grant, read-data valid and instruction word
//   redirect_valid/redirect_pc  - one-cycle redirect pulse and target
//   stall                       - decode cannot accept the presented instruction
//   inst_valid/inst/inst_pc     - presented instruction and its PC
//   pc4                         - inst_pc + 4 (combinational, link value)
//   misalign_err                - one-cycle pulse for a redirect with nonzero low bits
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc4,
  output logic        misalign_err
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        kill;

  // The fetch address is the PC flop itself, so a redirect shows up on the bus one cycle later.
  assign imem_addr = pc;
  assign pc4       = inst_pc + 32'd4;

  // Fetch FSM together with the PC, squash flag and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req_pc       <= RESET_PC;
      kill         <= 1'b0;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst         <= NOP_INST;
      inst_pc      <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      // A redirect always retargets the PC; the state-specific code below decides
      // what happens to any fetch already in flight.
      if (redirect_valid) begin
        pc <= align_word(redirect_pc);
      end
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            req_pc   <= pc;
            // Granted in the same cycle as a redirect: the response will be stale.
            kill     <= redirect_valid;
            imem_req <= 1'b0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill || redirect_valid) begin
              // Stale or just-redirected response: drop it and fetch from the new PC.
              kill     <= 1'b0;
              imem_req <= 1'b1;
              state    <= REQ;
            end else begin
              inst       <= imem_rdata;
              inst_pc    <= req_pc;
              pc         <= req_pc + 32'd4;
              inst_valid <= 1'b1;
              state      <= OUT;
            end
          end else if (redirect_valid) begin
            // Response still outstanding; remember to discard it when it arrives.
            kill <= 1'b1;
          end
        end
        OUT: begin
          if (redirect_valid || !stall) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= REQ;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc4;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  // memory-responder controls
  bit          fast = 1'b1;      // grant every request immediately
  int          fixed_lat = 1;    // >0: fixed rvalid latency after grant, else random 1..3
  bit          pend = 1'b0;      // a granted response is outstanding
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] gaddr = 32'h0;
  int          phase = 0;        // 1 = randomized redirect/stall traffic

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc4(pc4),
    .misalign_err(misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: a fixed hash of the address (address 0 holds addi x1,x0,5).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: grants requests and returns exactly one response per grant.
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (imem_rvalid) imem_rvalid = 1'b0;
      if (imem_gnt) begin
        imem_gnt = 1'b0;
        pend     = 1'b1;
        cnt      = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 3));
        paddr    = gaddr;
      end
      if (pend) begin
        if (cnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(paddr);
          pend        = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (imem_req && !pend && !imem_rvalid && !rst && (fast || $urandom_range(0, 2) != 0)) begin
        imem_gnt = 1'b1;
        gaddr    = imem_addr;
      end
    end
  end

  // Random redirect/stall traffic.
  initial begin
    logic [31:0] r;
    forever begin
      @(posedge clk);
      #2;
      if (phase == 1) begin
        stall = ($urandom_range(0, 2) == 0);
        r = $urandom;
        redirect_valid = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 2))
          0:       redirect_pc = {22'h0, r[9:0]};
          1:       redirect_pc = 32'hFFFF_FFF0 | {28'h0, r[3:0]};
          default: redirect_pc = r;
        endcase
      end
    end
  end

  // Scoreboard monitor. Reference model: the next instruction decode must see is the
  // one at the expected PC; a redirect replaces that expectation with the aligned
  // target, and every presented instruction advances it by 4 (modulo 2^32).
  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    bit          prev_valid;
    bit          prev_stall;
    bit          prev_redir;
    bit          exp_mis;
    int          idle_cnt;
    prev_valid = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; exp_mis = 1'b0;
    prev_inst = 32'h0; prev_pc = 32'h0; idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(32'h0000_0000);
        prev_valid = 1'b0;
        exp_mis    = 1'b0;
        idle_cnt   = 0;
      end else begin
        check("misalign_err", {31'h0, misalign_err}, {31'h0, exp_mis});
        if (imem_req) check("imem_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
        if (prev_valid) begin
          if (prev_stall && !prev_redir) begin
            check("hold_valid", {31'h0, inst_valid}, 32'h1);
            check("hold_inst", inst, prev_inst);
            check("hold_inst_pc", inst_pc, prev_pc);
            check("hold_no_req", {31'h0, imem_req}, 32'h0);
          end else begin
            check("release_valid", {31'h0, inst_valid}, 32'h0);
          end
        end else if (inst_valid) begin
          idle_cnt = 0;
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got inst_pc %h expected none", inst_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_inst_pc", inst_pc, e);
            check("sb_inst", inst, mem_word(e));
            check("sb_pc4", pc4, e + 32'd4);
            exp_q.push_back(e + 32'd4);
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_q.push_back({redirect_pc[31:2], 2'b00});
        end
        exp_mis    = redirect_valid && (redirect_pc[1:0] != 2'b00);
        prev_valid = inst_valid;
        prev_stall = stall;
        prev_redir = redirect_valid;
        prev_inst  = inst;
        prev_pc    = inst_pc;
        idle_cnt++;
        if (idle_cnt > 300) begin
          errors++;
          checks++;
          $display("FAIL liveness: got no instruction for %0d cycles expected fewer than 300", idle_cnt);
          idle_cnt = 0;
        end
      end
    end
  end

  // Bounded wait (sampled 2 time units after each rising edge) for inst_valid.
  task automatic wait_valid(input string name, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(posedge clk);
      #2;
      if (inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, {31'h0, seen}, 32'h1);
  endtask

  // Directed scenarios followed by randomized traffic.
  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", {31'h0, imem_req}, 32'h0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_misalign", {31'h0, misalign_err}, 32'h0);
    #1 rst = 1'b0;

    // First fetch, best-case handshake: valid after the third edge.
    @(posedge clk); #2;
    check("first_req", {31'h0, imem_req}, 32'h1);
    repeat (2) @(posedge clk);
    #2;
    check("t1_inst_valid", {31'h0, inst_valid}, 32'h1);
    check("t1_inst", inst, 32'h0050_0093);
    check("t1_inst_pc", inst_pc, 32'h0);
    check("t1_pc4", pc4, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      check("stall_inst_pc", inst_pc, 32'h0);
      check("stall_imem_req", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    @(posedge clk); #2;
    check("next_req", {31'h0, imem_req}, 32'h1);
    check("next_addr", imem_addr, 32'h4);
    fixed_lat = 3;

    // Redirect while waiting; the stale response comes two cycles later.
    @(posedge clk); #2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    fixed_lat = 1;
    wait_valid("t3_wait", 30);
    check("t3_inst_pc", inst_pc, 32'h0000_0100);

    // Redirect to 8, then redirect on its grant, then again on its rvalid.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0008;
    @(posedge clk); #2;
    redirect_pc = 32'h0000_0200;
    @(posedge clk); #2;
    redirect_pc = 32'h0000_0300;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("t4_addr", imem_addr, 32'h0000_0300);
    wait_valid("t4_wait", 30);
    check("t4_inst_pc", inst_pc, 32'h0000_0300);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    check("t5_misalign_on", {31'h0, misalign_err}, 32'h1);
    check("t5_addr", imem_addr, 32'h0000_0100);
    @(posedge clk); #2;
    check("t5_misalign_off", {31'h0, misalign_err}, 32'h0);
    wait_valid("t5_wait", 30);
    check("t5_inst_pc", inst_pc, 32'h0000_0100);

    // Randomized traffic.
    fast = 1'b0; fixed_lat = 0;
    @(negedge clk) phase = 1;
    repeat (4000) @(negedge clk);
    phase = 0;
    @(posedge clk); #2;
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    fast = 1'b1; fixed_lat = 3;

    // Reset while a response is outstanding; the late rvalid must be ignored.
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(posedge clk); #2;
        if (pend) begin
          hit = 1'b1;
          break;
        end
      end
      check("t6_pending", {31'h0, hit}, 32'h1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_valid", {31'h0, inst_valid}, 32'h0);
    #1 rst = 1'b0;
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #2;
        if (imem_rvalid) begin
          done = 1'b1;
          break;
        end
      end
      check("t6_late_rvalid", {31'h0, done}, 32'h1);
    end
    check("t6_late_valid", {31'h0, inst_valid}, 32'h0);
    check("t6_late_addr", imem_addr, 32'h0);
    wait_valid("t6_wait", 30);
    check("t6_inst_pc", inst_pc, 32'h0);
    check("t6_inst", inst, 32'h0050_0093);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog in case the bench itself stops advancing.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
